pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Merges the ID-stage load-use stall request, EX-stage multi-cycle operations (mult/div) and exception/branch flush requests into one stall vector and one flush/redirect.
- The stall vector drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 6, width of the EX multi-cycle count (max 63 stall cycles)
PERF_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
stallreq_id  in  1  ID load-use hazard; level, sampled each cycle
ex_start  in  1  EX begins a multi-cycle op this cycle
ex_cycles  in  CNT_W  number of stall cycles the op needs (N)
flush_req  in  1  exception/redirect request, 1-cycle pulse
flush_pc_i  in  32  redirect target, valid with flush_req
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  out  1  registered 1-cycle flush of all pipeline registers
new_pc  out  32  registered redirect PC, valid when flush=1
ex_done  out  1  registered 1-cycle pulse, multi-cycle op finished
busy  out  1  state==EX_BUSY
stall_cycles  out  PERF_W  count of cycles with stall[0]=1, saturating

Behaviour:
- Reset (rst=0 at a clk edge):
  - state<=IDLE; cnt<=0; flush<=0; new_pc<=0; ex_done<=0; stall_cycles<=0.
  - While rst=0, stall is forced to 0.
  - Reset mid-EX_BUSY aborts the op with no ex_done pulse.
- States:
  - IDLE: no EX op in progress.
  - EX_BUSY: EX op in progress; cnt holds the remaining stall cycles.
  - FLUSH: the flush cycle.
- Priority: flush_req > EX op (ex_start/EX_BUSY) > stallreq_id.
- stall is combinational from the current state and inputs:
  - flush_req=1 in any state -> 6'b000000.
  - state FLUSH -> 6'b000000; stallreq_id and ex_start are ignored this cycle.
  - state EX_BUSY -> 6'b001111.
  - IDLE with ex_start=1 and ex_cycles!=0 -> 6'b001111.
  - IDLE with stallreq_id=1 otherwise -> 6'b000111 (ID/EX receives a bubble).
  - all other cases -> 0.
- EX sequencing, N=ex_cycles, stall held for exactly N cycles including the start cycle:
  - IDLE, ex_start, N=0: ignored; no stall, no ex_done.
  - IDLE, ex_start, N=1: stall this cycle; stay IDLE; ex_done<=1.
  - IDLE, ex_start, N>=2: state<=EX_BUSY; cnt<=N-1.
  - EX_BUSY: cnt<=cnt-1. When cnt==1: state<=IDLE, ex_done<=1.
  - ex_start is ignored while in EX_BUSY; the held instruction may keep it asserted.
  - Because stall[3] is still 1 in the final stall cycle, ex_done goes high in the first unstalled cycle. In that cycle a still-asserted ex_start must not restart the op: a level held over from the last stall cycle is ignored; only a new rising ex_start is accepted.
- ex_done is high for one cycle only; it is 0 in all other cycles.
- Flush:
  - flush_req in any state: state<=FLUSH; flush<=1; new_pc<=flush_pc_i; cnt<=0; ex_done<=0 (a pending done is suppressed).
  - FLUSH: flush<=0 next edge; state<=IDLE unless flush_req is asserted again, in which case it stays FLUSH and new_pc is reloaded.
  - flush_req together with ex_start: the flush wins and the EX op never starts.
- stall_cycles increments by 1 on each clk edge at which stall[0]=1; it holds at all-ones (no wrap).
- busy = (state==EX_BUSY); it is 0 during the start cycle of an op and during FLUSH.

Test Plan:
- Reset: rst=0 for 2 cycles with stallreq_id=1 and ex_start=1 -> stall=0, flush=0, ex_done=0, stall_cycles=0; first cycle after rst=1 shows stall=6'b000111.
- Load-use: stallreq_id=1 for 1 cycle in IDLE -> stall=6'b000111 for that cycle only, stall_cycles=1, busy=0.
- Divide, ex_start with ex_cycles=5 -> stall=6'b001111 for exactly 5 cycles, busy=1 on cycles 2-5, ex_done=1 on cycle 6 only, stall_cycles=5; ex_start held through cycle 6 does not restart. Also ex_cycles=1 -> 1 stall cycle with ex_done next cycle; ex_cycles=0 -> no stall.
- Flush mid-op: ex_start with ex_cycles=10, then flush_req with flush_pc_i=32'hBFC00380 on cycle 4 -> stall=0 on cycle 4, flush=1 and new_pc=32'hBFC00380 on cycle 5, state IDLE on cycle 6, no ex_done ever.
- Simultaneous events: flush_req+ex_start+stallreq_id in one cycle -> stall=0, flush next cycle, no EX op. Back-to-back flush_req for 2 cycles -> flush=1 for 2 cycles, new_pc takes the second target.
- Saturation: preload stall_cycles to 2^PERF_W-2 via hierarchical force, then 3 stall cycles -> counter ends at all-ones.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges load-use, multi-cycle EX and flush requests
// into a stall vector, a registered flush/redirect and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              ex_start,
    input  logic [CNT_W-1:0]  ex_cycles,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc_i,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              ex_done,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExBusy = 2'd1,
        StFlush  = 2'd2
    } state_e;

    localparam logic [5:0] StallNone    = 6'b000000;
    localparam logic [5:0] StallLoadUse = 6'b000111;
    localparam logic [5:0] StallEx      = 6'b001111;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_flush;
    logic [31:0]        r_new_pc;
    logic               r_ex_done;
    logic               r_ex_start_d1;
    logic [PERF_W-1:0]  r_stall_cycles;

    state_e             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_flush_nxt;
    logic [31:0]        w_new_pc_nxt;
    logic               w_ex_done_nxt;
    logic [PERF_W-1:0]  w_stall_cycles_nxt;
    logic [5:0]         w_stall;
    logic               w_ex_start_ok;
    logic               w_ex_n_zero;
    logic               w_ex_n_one;

    // In the cycle right after an op completes, a start level carried over from the held
    // instruction must not relaunch it; only a fresh assertion counts.
    assign w_ex_start_ok = ex_start && !(r_ex_done && r_ex_start_d1);
    assign w_ex_n_zero   = (ex_cycles == '0);
    assign w_ex_n_one    = (ex_cycles == CNT_W'(1));

    always_comb begin
        w_stall = StallNone;
        if (!rst || flush_req) begin
            w_stall = StallNone;
        end else begin
            unique case (r_state)
                StFlush:  w_stall = StallNone;
                StExBusy: w_stall = StallEx;
                default: begin
                    if (w_ex_start_ok && !w_ex_n_zero) begin
                        w_stall = StallEx;
                    end else if (stallreq_id) begin
                        w_stall = StallLoadUse;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_flush_nxt   = 1'b0;
        w_new_pc_nxt  = r_new_pc;
        w_ex_done_nxt = 1'b0;
        if (flush_req) begin
            // Flush wins over everything and cancels any pending completion.
            w_state_nxt  = StFlush;
            w_flush_nxt  = 1'b1;
            w_new_pc_nxt = flush_pc_i;
            w_cnt_nxt    = '0;
        end else begin
            unique case (r_state)
                StFlush: begin
                    w_state_nxt = StIdle;
                end
                StExBusy: begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt   = StIdle;
                        w_ex_done_nxt = 1'b1;
                    end
                end
                default: begin
                    if (w_ex_start_ok && w_ex_n_one) begin
                        w_ex_done_nxt = 1'b1;
                    end else if (w_ex_start_ok && !w_ex_n_zero) begin
                        w_state_nxt = StExBusy;
                        w_cnt_nxt   = ex_cycles - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_stall_cycles_nxt = r_stall_cycles;
        if (w_stall[0] && !(&r_stall_cycles)) begin
            w_stall_cycles_nxt = r_stall_cycles + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_flush        <= 1'b0;
            r_new_pc       <= '0;
            r_ex_done      <= 1'b0;
            r_ex_start_d1  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_flush        <= w_flush_nxt;
            r_new_pc       <= w_new_pc_nxt;
            r_ex_done      <= w_ex_done_nxt;
            r_ex_start_d1  <= ex_start;
            r_stall_cycles <= w_stall_cycles_nxt;
        end
    end

    assign stall        = w_stall;
    assign flush        = r_flush;
    assign new_pc       = r_new_pc;
    assign ex_done      = r_ex_done;
    assign busy         = (r_state == StExBusy);
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic, all compared
// against a cycle-level model built from remaining-stall-cycle bookkeeping.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned PERF_W = 32;

    logic              clk;
    logic              rst;
    logic              stallreq_id;
    logic              ex_start;
    logic [CNT_W-1:0]  ex_cycles;
    logic              flush_req;
    logic [31:0]       flush_pc_i;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              ex_done;
    logic              busy;
    logic [PERF_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int          m_rem;       // stall cycles still owed by the running op (excluding start)
    bit          m_flushing;
    bit          m_flush;
    logic [31:0] m_pc;
    bit          m_done;
    bit          m_prev_start;
    logic [31:0] m_perf;
    int          done_seen;

    pipe_ctrl #(
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_start     (ex_start),
        .ex_cycles    (ex_cycles),
        .flush_req    (flush_req),
        .flush_pc_i   (flush_pc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .ex_done      (ex_done),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit start_ok();
        return ex_start && !(m_done && m_prev_start);
    endfunction

    function automatic logic [5:0] exp_stall();
        if (!rst || flush_req || m_flushing) return 6'b000000;
        if (m_rem > 0) return 6'b001111;
        if (start_ok() && ex_cycles != 0) return 6'b001111;
        if (stallreq_id) return 6'b000111;
        return 6'b000000;
    endfunction

    // Check the current cycle, then advance the model across the next rising edge.
    task automatic run_cycle();
        logic [5:0] es;
        bit ok;
        #1;
        es = exp_stall();
        ok = start_ok();
        check("stall", {26'd0, stall}, {26'd0, es});
        check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
        check("flush", {31'd0, flush}, {31'd0, m_flush});
        check("new_pc", new_pc, m_pc);
        check("ex_done", {31'd0, ex_done}, {31'd0, m_done});
        check("stall_cycles", stall_cycles, m_perf);
        if (ex_done) done_seen++;
        @(posedge clk);
        if (!rst) begin
            m_rem = 0; m_flushing = 0; m_flush = 0; m_pc = '0;
            m_done = 0; m_prev_start = 0; m_perf = '0;
        end else begin
            if (es[0] && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
            if (flush_req) begin
                m_flushing = 1; m_flush = 1; m_pc = flush_pc_i; m_rem = 0; m_done = 0;
            end else if (m_flushing) begin
                m_flushing = 0; m_flush = 0; m_done = 0;
            end else if (m_rem > 0) begin
                m_flush = 0;
                m_rem--;
                m_done = (m_rem == 0);
            end else begin
                m_flush = 0;
                m_done = ok && (ex_cycles == 1);
                if (ok && ex_cycles >= 2) m_rem = int'(ex_cycles) - 1;
            end
            m_prev_start = ex_start;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit sid, input bit es, input int n,
                         input bit fr, input logic [31:0] pc);
        rst = r; stallreq_id = sid; ex_start = es; ex_cycles = CNT_W'(n);
        flush_req = fr; flush_pc_i = pc;
    endtask

    initial begin
        int perf0;
        m_rem = 0; m_flushing = 0; m_flush = 0; m_pc = '0;
        m_done = 0; m_prev_start = 0; m_perf = '0; done_seen = 0;
        drive(0, 1, 1, 3, 0, 32'h0);
        @(negedge clk);

        // Reset with requests asserted, then release into a load-use stall
        repeat (2) run_cycle();
        drive(1, 1, 0, 0, 0, 32'h0);
        run_cycle();
        check("post_reset_perf", stall_cycles, 32'd1);
        drive(1, 0, 0, 0, 0, 32'h0);
        run_cycle();

        // Divide, N=5, start held through the first unstalled cycle
        perf0 = int'(stall_cycles);
        drive(1, 0, 1, 5, 0, 32'h0);
        repeat (6) run_cycle();
        check("div_perf_delta", stall_cycles - 32'(perf0), 32'd5);
        drive(1, 0, 0, 0, 0, 32'h0);
        repeat (2) run_cycle();

        // N=1 and N=0
        drive(1, 0, 1, 1, 0, 32'h0);
        run_cycle();
        drive(1, 0, 0, 0, 0, 32'h0);
        run_cycle();
        check("n1_done", {31'd0, ex_done}, 32'd0);
        drive(1, 0, 1, 0, 0, 32'h0);
        run_cycle();
        drive(1, 0, 0, 0, 0, 32'h0);
        run_cycle();

        // Flush mid-op
        done_seen = 0;
        drive(1, 0, 1, 10, 0, 32'h0);
        repeat (3) run_cycle();
        drive(1, 0, 1, 10, 1, 32'hBFC0_0380);
        run_cycle();
        drive(1, 0, 0, 0, 0, 32'h0);
        repeat (12) run_cycle();
        check("flush_no_done", 32'(done_seen), 32'd0);

        // Everything at once, then back-to-back flushes
        drive(1, 1, 1, 4, 1, 32'h0000_1234);
        run_cycle();
        drive(1, 0, 0, 0, 1, 32'h0000_AAAA);
        run_cycle();
        drive(1, 0, 0, 0, 1, 32'h0000_BBBB);
        run_cycle();
        drive(1, 0, 0, 0, 0, 32'h0);
        repeat (3) run_cycle();
        check("b2b_pc", new_pc, 32'h0000_BBBB);

        // Counter saturation
        force dut.r_stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cycles;
        m_perf = 32'hFFFF_FFFE;
        drive(1, 1, 0, 0, 0, 32'h0);
        repeat (3) run_cycle();
        drive(1, 0, 0, 0, 0, 32'h0);
        run_cycle();
        check("sat", stall_cycles, 32'hFFFF_FFFF);

        // Reset mid-op, then random traffic
        drive(1, 0, 1, 8, 0, 32'h0);
        repeat (3) run_cycle();
        drive(0, 0, 0, 0, 0, 32'h0);
        run_cycle();
        for (int i = 0; i < 3000; i++) begin
            bit r, sid, es, fr;
            int n;
            r   = ($urandom_range(0, 199) != 0);
            sid = ($urandom_range(0, 3) == 0);
            fr  = ($urandom_range(0, 24) == 0);
            if (ex_start && $urandom_range(0, 9) < 7) begin
                es = 1; n = int'(ex_cycles);
            end else begin
                es = ($urandom_range(0, 6) == 0);
                n  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
            end
            drive(r, sid, es, n, fr, $urandom);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
